// File: rtl/mem_master.sv
// ----------------------------------------------------------------------------
// mem_master
//
// Bus initiator between the CPU datapath and the handshaked `ram` block.
// Each CPU load/store request is turned into a single ram read or write
// handshake. A simultaneous load+store becomes a write followed by a read of
// the same word (read-after-write). The block returns the load data and a
// fault code with a one-cycle `done` pulse. Byte addresses become word
// addresses (addr[31:2], zero-extended), and misaligned requests are refused
// without touching the ram.
//
// Optional feature: define MEM_MASTER_TIMEOUT_EN to enable the watchdog. When
// enabled, a wait state that has seen neither a ready nor `exc` after TIMEOUT
// counted edges ends with fault 3. Without the macro the master waits
// indefinitely.
//
// Parameters:
//   TIMEOUT    wait-state edges before a timeout fault (1 .. 2**CNT_W-1)
//   CNT_W      width of the wait counter
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_rd, req_wr      CPU load / store request (sampled only in IDLE)
//   req_addr            byte address of the request
//   req_wdata           store data
//   busy                high in every state except IDLE
//   done                one-cycle completion pulse
//   rdata               load result, valid while done
//   fault_code          0 none, 1 misaligned, 2 range (exc), 3 timeout
//   r_addr, w_addr      word addresses to the ram
//   w_line              write data to the ram
//   read, write         ram access strobes
//   r_line              ram read data, captured only on rrdy
//   rrdy, wrdy          ram read / write ready pulses
//   exc                 ram range exception level
// ----------------------------------------------------------------------------
module mem_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  fault_code,
    output logic [31:0] r_addr,
    output logic [31:0] w_addr,
    output logic [31:0] w_line,
    output logic        read,
    output logic        write,
    input  logic [31:0] r_line,
    input  logic        rrdy,
    input  logic        wrdy,
    input  logic        exc
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'd0;
    localparam logic [1:0] FLT_ALIGN   = 2'd1;
    localparam logic [1:0] FLT_RANGE   = 2'd2;
    localparam logic [1:0] FLT_TIMEOUT = 2'd3;

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    state_t            state, state_nxt;

    logic [CNT_W-1:0]  cnt, cnt_nxt, cnt_inc;
    logic              pend_rd, pend_nxt;
    logic [31:0]       addr_q, addr_nxt;

    logic              busy_nxt, done_nxt, read_nxt, write_nxt;
    logic [31:0]       rdata_nxt, r_addr_nxt, w_addr_nxt, w_line_nxt;
    logic [1:0]        fault_nxt;

    logic              accept, misaligned;
    logic [31:0]       word_in;
    logic              resp_en, wr_ok, rd_ok, rng_err, tmo_hit;

    // ------------------------------------------------------------------
    // Request decode and response qualification
    // ------------------------------------------------------------------
    assign accept     = req_rd | req_wr;
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign word_in    = {2'b00, req_addr[31:2]};

    // Responses are ignored on the first wait edge: the ram samples the strobe
    // on that edge, so `exc` is still the level left over from the previous
    // access until then.
    assign resp_en = (cnt != '0);
    assign wr_ok   = resp_en & wrdy;
    assign rd_ok   = resp_en & rrdy;
    assign rng_err = resp_en & exc;

    // The counter saturates at TMO_LIMIT. That is the only count the watchdog
    // needs, and it keeps resp_en from wrapping back to 0 during a long wait.
    assign cnt_inc = (cnt == TMO_LIMIT) ? cnt : cnt + CNT_W'(1);

`ifdef MEM_MASTER_TIMEOUT_EN
    assign tmo_hit = (cnt >= TMO_LIMIT);
`else
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (misaligned)  state_nxt = ST_RESP;
                    else if (req_wr) state_nxt = ST_WR_WAIT;
                    else             state_nxt = ST_RD_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (wr_ok)                   state_nxt = pend_rd ? ST_RD_WAIT : ST_RESP;
                else if (rng_err || tmo_hit) state_nxt = ST_RESP;
            end
            ST_RD_WAIT: begin
                if (rd_ok || rng_err || tmo_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                // Stay until the done pulse has been presented.
                if (done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values (registered below)
    // ------------------------------------------------------------------
    // NOTE: every signal gets a hold-value default first, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        busy_nxt   = (state_nxt != ST_IDLE);
        done_nxt   = 1'b0;
        rdata_nxt  = rdata;
        fault_nxt  = fault_code;
        r_addr_nxt = r_addr;
        w_addr_nxt = w_addr;
        w_line_nxt = w_line;
        read_nxt   = read;
        write_nxt  = write;
        cnt_nxt    = cnt;
        pend_nxt   = pend_rd;
        addr_nxt   = addr_q;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    addr_nxt = word_in;
                    cnt_nxt  = '0;
                    pend_nxt = 1'b0;
                    if (misaligned) begin
                        fault_nxt = FLT_ALIGN;
                        rdata_nxt = '0;
                    end else if (req_wr) begin
                        w_addr_nxt = word_in;
                        w_line_nxt = req_wdata;
                        write_nxt  = 1'b1;
                        pend_nxt   = req_rd;
                    end else begin
                        r_addr_nxt = word_in;
                        read_nxt   = 1'b1;
                    end
                end
            end

            ST_WR_WAIT: begin
                cnt_nxt = cnt_inc;
                if (wr_ok) begin
                    // Strobe drops on the edge the ready is seen, so the ram
                    // never starts a second write.
                    write_nxt = 1'b0;
                    if (pend_rd) begin
                        r_addr_nxt = addr_q;
                        read_nxt   = 1'b1;
                        cnt_nxt    = '0;
                        pend_nxt   = 1'b0;
                    end else begin
                        fault_nxt = FLT_NONE;
                        done_nxt  = 1'b1;
                    end
                end else if (rng_err) begin
                    write_nxt = 1'b0;
                    pend_nxt  = 1'b0;
                    fault_nxt = FLT_RANGE;
                    done_nxt  = 1'b1;
                end else if (tmo_hit) begin
                    write_nxt = 1'b0;
                    pend_nxt  = 1'b0;
                    fault_nxt = FLT_TIMEOUT;
                    rdata_nxt = '0;
                    done_nxt  = 1'b1;
                end
            end

            ST_RD_WAIT: begin
                cnt_nxt = cnt_inc;
                if (rd_ok) begin
                    read_nxt  = 1'b0;
                    rdata_nxt = r_line;
                    fault_nxt = FLT_NONE;
                    done_nxt  = 1'b1;
                end else if (rng_err) begin
                    read_nxt  = 1'b0;
                    rdata_nxt = '0;
                    fault_nxt = FLT_RANGE;
                    done_nxt  = 1'b1;
                end else if (tmo_hit) begin
                    read_nxt  = 1'b0;
                    rdata_nxt = '0;
                    fault_nxt = FLT_TIMEOUT;
                    done_nxt  = 1'b1;
                end
            end

            ST_RESP: begin
                // Wait-state exits enter RESP with done already set, so RESP
                // lasts one cycle. The misaligned path enters with done low,
                // so done rises one edge later and that completion lands one
                // edge after accept.
                done_nxt = ~done;
            end

            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Output and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            rdata      <= '0;
            fault_code <= FLT_NONE;
            r_addr     <= '0;
            w_addr     <= '0;
            w_line     <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            cnt        <= '0;
            pend_rd    <= 1'b0;
            addr_q     <= '0;
        end else begin
            busy       <= busy_nxt;
            done       <= done_nxt;
            rdata      <= rdata_nxt;
            fault_code <= fault_nxt;
            r_addr     <= r_addr_nxt;
            w_addr     <= w_addr_nxt;
            w_line     <= w_line_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            cnt        <= cnt_nxt;
            pend_rd    <= pend_nxt;
            addr_q     <= addr_nxt;
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// ----------------------------------------------------------------------------
// tb_mem_master
//
// Self-checking bench for mem_master. A behavioural 1024-word ram responder
// answers the strobes with a programmable delay. Expected completion latency,
// fault code, load data and memory contents come from a transaction-level
// model, which uses the address rules and a reference memory array.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_master;

    localparam int TIMEOUT   = 16;
    localparam int RAM_WORDS = 1024;
    localparam int MAX_WAIT  = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [31:0] req_addr, req_wdata;
    logic        busy, done;
    logic [31:0] rdata;
    logic [1:0]  fault_code;
    logic [31:0] r_addr, w_addr, w_line;
    logic        read, write;
    logic [31:0] r_line;
    logic        rrdy, wrdy, exc;

    mem_master #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_rd     (req_rd),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .fault_code (fault_code),
        .r_addr     (r_addr),
        .w_addr     (w_addr),
        .w_line     (w_line),
        .read       (read),
        .write      (write),
        .r_line     (r_line),
        .rrdy       (rrdy),
        .wrdy       (wrdy),
        .exc        (exc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Ram responder: works on the falling edge, so what it sees is what the
    // ram samples on the next rising edge. `exc` is refreshed one edge after
    // the access is sampled. A ready pulse follows after ram_delay more edges.
    // ------------------------------------------------------------------
    logic [31:0] ram_mem [RAM_WORDS];
    logic [31:0] ref_mem [RAM_WORDS];
    int          ram_delay = 0;
    bit          ram_hold  = 1'b0;

    initial begin : ram_model
        int          phase;     // 0 idle, 1 access in progress, 2 pulse out
        int          left;
        bit          first, is_wr, oor;
        logic [31:0] word;
        rrdy   = 1'b0;
        wrdy   = 1'b0;
        exc    = 1'b0;
        r_line = '0;
        phase  = 0;
        left   = 0;
        first  = 1'b0;
        is_wr  = 1'b0;
        oor    = 1'b0;
        word   = '0;
        forever begin
            @(negedge clk);
            if (phase == 2) begin
                rrdy  = 1'b0;
                wrdy  = 1'b0;
                phase = 0;
            end
            if (phase == 1 && read !== 1'b1 && write !== 1'b1) phase = 0;
            if (phase == 0) begin
                if (write === 1'b1 || read === 1'b1) begin
                    is_wr = (write === 1'b1);
                    word  = is_wr ? w_addr : r_addr;
                    oor   = (word >= RAM_WORDS);
                    left  = ram_delay;
                    first = 1'b1;
                    phase = 1;
                    if (is_wr && !oor) ram_mem[word[9:0]] = w_line;
                end
            end else if (phase == 1) begin
                if (first) begin
                    exc   = oor;
                    first = 1'b0;
                end
                if (oor) begin
                    phase = 2;
                end else if (!ram_hold) begin
                    if (left == 0) begin
                        if (is_wr) begin
                            wrdy = 1'b1;
                        end else begin
                            rrdy   = 1'b1;
                            r_line = ram_mem[word[9:0]];
                        end
                        phase = 2;
                    end else begin
                        left--;
                    end
                end
            end
            if (!rrdy) r_line = $urandom;
        end
    end

    // ------------------------------------------------------------------
    // Transaction-level reference and driver
    // ------------------------------------------------------------------
    logic [31:0] exp_rdata = '0;

    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int d, input bit hold);
        logic [31:0] w;
        bit          mis, oor;
        int          exp_lat, lat;
        logic [1:0]  exp_flt;

        w   = {2'b00, addr[31:2]};
        mis = (addr[1:0] != 2'b00);
        oor = (w >= RAM_WORDS);

        if (mis) begin
            exp_lat   = 1;
            exp_flt   = 2'd1;
            exp_rdata = '0;
        end else if (hold) begin
            exp_lat   = TIMEOUT + 1;
            exp_flt   = 2'd3;
            exp_rdata = '0;
        end else if (oor) begin
            exp_lat = 2;
            exp_flt = 2'd2;
            if (!wr) exp_rdata = '0;
        end else begin
            exp_flt = 2'd0;
            if (wr) ref_mem[w[9:0]] = wdata;
            exp_lat = (wr && rd) ? 4 + 2 * d : 2 + d;
            if (rd) exp_rdata = ref_mem[w[9:0]];
        end

        ram_delay = d;
        ram_hold  = hold;
        @(negedge clk);
        req_rd    = rd;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        check("busy_after_accept", 32'(busy), 32'd1);
        @(negedge clk);
        req_rd = 1'b0;
        req_wr = 1'b0;

        lat = 0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(posedge clk);
            #1;
            if (mis) check("misaligned_no_strobe", 32'({read, write}), 32'd0);
            if (done) begin
                lat = k;
                break;
            end
        end

        check("done_latency", 32'(lat), 32'(exp_lat));
        check("fault_code", 32'(fault_code), 32'(exp_flt));
        check("rdata", rdata, exp_rdata);
        check("strobes_at_done", 32'({read, write}), 32'd0);
        if (!mis && !oor && wr) begin
            check("w_addr", w_addr, w);
            check("w_line", w_line, wdata);
        end
        if (!mis && !oor && rd && (!wr || !hold)) check("r_addr", r_addr, w);

        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_back_idle", 32'(busy), 32'd0);
        ram_hold = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [31:0] v, a;
        int          sel, kind;
        bit          saw_done;

        rst       = 1'b1;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < RAM_WORDS; i++) begin
            v          = $urandom;
            ram_mem[i] = v;
            ref_mem[i] = v;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobes", 32'({read, write}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_fault", 32'(fault_code), 32'd0);
        check("rst_r_addr", r_addr, 32'd0);
        check("rst_w_addr", w_addr, 32'd0);
        check("rst_w_line", w_line, 32'd0);
        rst = 1'b0;

        // Directed cases
        run_txn(1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h10,   32'h0,        0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h6,    32'h0,        0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h1000, 32'h0,        0, 1'b0);
        run_txn(1'b1, 1'b0, 32'h0,    32'h0,        0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h20,   32'h12345678, 0, 1'b0);
        run_txn(1'b1, 1'b1, 32'h24,   32'hA5A5_0F0F, 2, 1'b0);
        run_txn(1'b1, 1'b1, 32'h2000, 32'h1111_2222, 0, 1'b0);

`ifdef MEM_MASTER_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 32'h40,   32'h0,        0, 1'b1);
`else
        run_txn(1'b1, 1'b0, 32'h40,   32'h0,        40, 1'b0);
`endif

        // Reset pulsed at E1 of a read: aborts silently, no done
        ram_delay = 3;
        @(negedge clk);
        req_rd   = 1'b1;
        req_addr = 32'h44;
        @(posedge clk);
        @(negedge clk);
        req_rd = 1'b0;
        rst    = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_read", 32'(read), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        exp_rdata = '0;
        check("midrst_rdata", rdata, 32'd0);
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            sel  = $urandom_range(0, 9);
            kind = $urandom_range(0, 2);
            if (sel < 6)      a = 32'($urandom_range(0, 15)) << 2;
            else if (sel < 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else              a = 32'($urandom_range(1024, 4095)) << 2;
            run_txn(kind != 1, kind != 0, a, $urandom, $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_master.md
# mem_master

Bus initiator that turns single CPU load/store requests into the `ram` read/write handshake and returns data plus a fault code. It sits between the CPU datapath and the handshaked `ram` block. It serialises accesses, converts byte addresses to word addresses and checks alignment. It waits for `rrdy`/`wrdy`/`exc`, with an optional watchdog timeout.

## Interface
Parameters:
- `TIMEOUT`, 16, number of wait-state edges without a response before a timeout fault (1..2^CNT_W-1).
- `CNT_W`, 8, width of the wait counter.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_rd` in 1: CPU load request; sampled only in IDLE.
- `req_wr` in 1: CPU store request; sampled only in IDLE.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: load result; valid while `done`=1.
- `fault_code` out 2: 0 none, 1 misaligned, 2 range (`exc`), 3 timeout; valid while `done`=1.
- `r_addr` out 32: word read address to `ram`.
- `w_addr` out 32: word write address to `ram`.
- `w_line` out 32: write data to `ram`.
- `read` out 1: read strobe to `ram`.
- `write` out 1: write strobe to `ram`.
- `r_line` in 32: read data from `ram`; may be Z when `read`=0 and is captured only on `rrdy`.
- `rrdy` in 1: read-ready pulse from `ram`.
- `wrdy` in 1: write-ready pulse from `ram`.
- `exc` in 1: range exception from `ram`; level, refreshed on every ram-sampled access.

## Operation
- **States:** IDLE, WR_WAIT, RD_WAIT, RESP. All outputs are registered.
- **IDLE with `req_rd|req_wr`:**
  - Latch the request; word address = `req_addr[31:2]` zero-extended.
  - If `req_addr[1:0]!=0`: go to RESP with fault 1, `rdata`=0, no ram access.
  - Else if `req_wr`: `w_addr`, `w_line`, `write`<=1; go to WR_WAIT; cnt<=0. A pending read flag is set if `req_rd` was also high.
  - Else: `r_addr`, `read`<=1; go to RD_WAIT; cnt<=0.
- **WR_WAIT/RD_WAIT:**
  - cnt increments every edge.
  - Responses are evaluated only when cnt>=1, so the ram has sampled the strobe and `exc` is fresh rather than stale from a prior fault.
  - Evaluation priority: ready, then `exc`, then timeout.
- **WR_WAIT:**
  - `wrdy`: `write`<=0. If a read is pending, `r_addr`, `read`<=1, go to RD_WAIT, cnt<=0. Otherwise go to RESP with fault 0 and `rdata` unchanged.
  - `exc`: `write`<=0; go to RESP with fault 2. A pending read is dropped.
- **RD_WAIT:**
  - `rrdy`: `rdata`<=`r_line`, `read`<=0; go to RESP with fault 0.
  - `exc`: `read`<=0, `rdata`<=0; go to RESP with fault 2.
- **RESP:** `done`=1 for exactly one cycle, then IDLE. Requests are not sampled in RESP.
- **Simultaneous `req_rd` and `req_wr`:** write first, then read of the same address (read-after-write). A single `done` is issued at the end.
- **Strobe release:** strobes drop on the same edge the ready is observed, so the ram never performs a second access.
- **Reset values:** state IDLE; `busy`, `done`, `read`, `write` = 0; `rdata`, `r_addr`, `w_addr`, `w_line` = 0; `fault_code` = 0.
- **Reset mid-operation:** aborts the transfer and drops strobes on the reset edge; no `done` is issued. A write already sampled by the ram may still commit.

## Timing
Accept edge is E0.
- **Write-only:** `write` high after E0; ram samples at E1; `wrdy` observed at E2; `done` high between E2 and E3; `busy` low after E3.
- **Read-only:** same as write-only; `rdata` registered at E2.
- **Read+write:** `read` issued at E2; `done` between E4 and E5.
- **Misaligned:** `done` between E1 and E2.
- **Range fault:** same latency as a successful access.
- **Back-to-back:** minimum request spacing is 4 edges for single accesses.

## Configuration
- `MEM_MASTER_TIMEOUT_EN` defined: when cnt reaches `TIMEOUT` with no ready and no `exc`, drop strobes, go to RESP with fault 3, `rdata`=0.
- Not defined: no watchdog. Waits indefinitely, fault 3 is never produced, and `TIMEOUT` is unused.

## Test plan
- Store `req_addr`=0x10, `req_wdata`=0xDEADBEEF, then load 0x10 -> `w_addr`=4, `done` 2 edges after each accept, `rdata`=0xDEADBEEF, `fault_code`=0.
- Load `req_addr`=0x6 -> no `read` asserted, `done` at E1, `fault_code`=1, `rdata`=0.
- Load byte address 0x1000 with 1024-word ram -> `exc`, `fault_code`=2, `rdata`=0. Then load 0x0 -> `fault_code`=0 (stale `exc` ignored).
- `req_rd`=`req_wr`=1, addr 0x20, data 0x12345678 -> write then read, single `done` at E4, `rdata`=0x12345678.
- Macro on, `TIMEOUT`=16, ram responder held off -> `done` with `fault_code`=3 after 16 wait edges, strobes low.
- `rst` pulsed at E1 of a read -> `read`, `busy`, `done`=0 after that edge, state IDLE, next request served normally.
